data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Clocked, parametrised data memory for the pipeline MEM stage. Byte-addressed, little-endian.
//  Supports byte, half-word and word accesses, with sign or zero extension on loads.
//  A req/ready/ack handshake with programmable latency lets the core model memory stalls.
//  Reports misaligned or out-of-range accesses as errors instead of corrupting memory.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; power of 2, >= 4
//  LATENCY      1    cycles from request acceptance to ack; 1..15
// PORTS
//  clk_i      in   1   clock; all state updates on rising edge
//  rst_i      in   1   asynchronous, active-low reset
//  req_i      in   1   access request; sampled only while ready_o=1
//  we_i       in   1   1=store, 0=load
//  size_i     in   2   00=byte, 01=half, 10=word, 11=illegal
//  sign_i     in   1   loads: 1=sign-extend, 0=zero-extend; ignored for word/stores
//  addr_i     in   32  byte address
//  wdata_i    in   32  store data; low byte/half used for byte/half stores
//  ready_o    out  1   controller idle; a request can be accepted
//  ack_o      out  1   one-cycle pulse: access complete, rdata_o/err_o valid
//  rdata_o    out  32  load result; held until next ack
//  err_o      out  1   valid with ack_o: access rejected
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, ready_o=1, ack_o=0, err_o=0, rdata_o=0, counter=0.
//   Memory array is NOT reset. An in-flight access is aborted with no write.
//  FSM states: IDLE, BUSY, RESP.
//   IDLE: ready_o=1. On req_i=1 at an edge, latch we/size/sign/addr/wdata, load cnt=LATENCY-1, go to BUSY.
//    req_i in any other state is ignored, not queued.
//   BUSY: if cnt!=0, decrement; if cnt==0, perform the access at this edge, register rdata_o/err_o, go to RESP.
//   RESP: ack_o=1 for exactly one cycle, ready_o=0; next edge -> IDLE.
//  Timing: request accepted at edge N; ack_o is high in the cycle after edge N+LATENCY.
//   Throughput is one access per LATENCY+2 cycles.
//  Address decode: word index = addr[log2(DEPTH_WORDS)+1:2]; lane = addr[1:0].
//  Error conditions, checked at access time; error still takes full latency:
//   - size=11.
//   - half with addr[0]=1.
//   - word with addr[1:0]!=0.
//   - addr[31:log2(DEPTH_WORDS)+2] != 0 (out of range).
//   On error: no memory write, err_o=1, rdata_o=0.
//  Store: write only the addressed lane(s). Byte -> lane addr[1:0]; half -> lanes addr[1]*2 +{0,1}.
//   Other bytes of the word are unchanged. On store ack: rdata_o=0, err_o=0.
//  Load: select lane(s), then extend to 32 bits per sign_i. Word loads return the full word.
//  Back-to-back access: a store immediately followed by a load of the same address returns the new data.
//  ready_o and ack_o are never high in the same cycle.
// TESTING
//  1. Reset mid-access: LATENCY=3, store 0xDEADBEEF @0x10, drop rst_i in BUSY.
//     -> ready_o=1, ack_o=0 immediately; a later load @0x10 must not return 0xDEADBEEF.
//  2. Latency: LATENCY=4, word store 0x12345678 @0x8, accepted at edge N.
//     -> ack_o high only in the cycle after edge N+4; err_o=0.
//  3. Byte/half merge: word 0x12345678 @0x8; byte store 0xAA @0xB; half store 0xBEEF @0x8.
//     -> word load @0x8 = 0xAA34BEEF.
//  4. Extension: word 0x80FF7F01 @0x0.
//     -> lb @0x2 sign=1 = 0xFFFFFFFF; lbu @0x3 = 0x00000080; lh @0x2 sign=1 = 0xFFFF80FF; lhu @0x0 = 0x00007F01.
//  5. Errors, DEPTH_WORDS=256: word @0x6, half @0x5, size=11 @0x0, word @0x400.
//     -> each acks with err_o=1, rdata_o=0; memory unchanged.
//  6. Ignored request: hold req_i=1 continuously with LATENCY=1.
//     -> exactly one acceptance per 3 cycles; no ack while ready_o=1.

Source files
------------

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_ctrl
// Description : Byte-addressed little-endian data memory with a req/ready/ack
//               handshake, programmable latency and access error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        sign_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        ack_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic        capture, do_access;

   logic        acc_we;
   logic [1:0]  acc_size;
   logic        acc_sign;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;

   logic [31:0] mem [DEPTH_WORDS];

   logic [AW-1:0] word_idx;
   logic [1:0]    lane;
   logic          range_err, align_err, access_err;
   logic [31:0]   mem_word, load_data, wr_data;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [3:0]    byte_en;
   logic          mem_write;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rdata_o   <= 32'd0;
         err_o     <= 1'b0;
         acc_we    <= 1'b0;
         acc_size  <= 2'b00;
         acc_sign  <= 1'b0;
         acc_addr  <= 32'd0;
         acc_wdata <= 32'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (capture) begin
            acc_we    <= we_i;
            acc_size  <= size_i;
            acc_sign  <= sign_i;
            acc_addr  <= addr_i;
            acc_wdata <= wdata_i;
         end
         if (do_access) begin
            err_o   <= access_err;
            rdata_o <= (access_err || acc_we) ? 32'd0 : load_data;
         end
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      capture    = 1'b0;
      do_access  = 1'b0;
      ready_o    = 1'b0;
      ack_o      = 1'b0;
      case (state)
         IDLE: begin
            ready_o = 1'b1;
            if (req_i) begin
               capture    = 1'b1;
               cnt_next   = CNT_INIT;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (cnt != 4'd0) begin
               cnt_next = cnt - 4'd1;
            end else begin
               do_access  = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            ack_o      = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Decode and validate the latched request
   assign word_idx  = acc_addr[AW+1:2];
   assign lane      = acc_addr[1:0];
   assign range_err = |acc_addr[31:AW+2];

   always_comb begin
      align_err = 1'b0;
      case (acc_size)
         2'b00:   align_err = 1'b0;
         2'b01:   align_err = acc_addr[0];
         2'b10:   align_err = |acc_addr[1:0];
         default: align_err = 1'b1;
      endcase
   end

   assign access_err = range_err | align_err;
   assign mem_word   = mem[word_idx];
   assign byte_sel   = mem_word[{lane, 3'b000} +: 8];
   assign half_sel   = mem_word[{lane[1], 4'b0000} +: 16];

   always_comb begin
      load_data = mem_word;
      wr_data   = acc_wdata;
      byte_en   = 4'b1111;
      case (acc_size)
         2'b00: begin
            load_data = acc_sign ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
            wr_data   = {4{acc_wdata[7:0]}};
            byte_en   = 4'b0001 << lane;
         end
         2'b01: begin
            load_data = acc_sign ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
            wr_data   = {2{acc_wdata[15:0]}};
            byte_en   = lane[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            load_data = mem_word;
            wr_data   = acc_wdata;
            byte_en   = 4'b1111;
         end
      endcase
   end

   // A reset forces IDLE, so an aborted access never reaches the write strobe
   assign mem_write = do_access & acc_we & ~access_err;

   always_ff @(posedge clk_i) begin
      if (mem_write) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// Testbench for data_memory_ctrl: directed accesses checked against a queue of
// expected responses, plus a throughput check on a second, minimum-latency instance.
module tb_data_memory_ctrl;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, we, sign;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        ready, ack, err;
   logic [31:0] rdata;

   logic        req1, ready1, ack1, err1;
   logic [31:0] rdata1;

   int checks   = 0;
   int failures = 0;
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   data_memory_ctrl #(.DEPTH_WORDS(256), .LATENCY(LAT)) u_dut (
      .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .size_i(size),
      .sign_i(sign), .addr_i(addr), .wdata_i(wdata), .ready_o(ready),
      .ack_o(ack), .rdata_o(rdata), .err_o(err)
   );

   data_memory_ctrl #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst_n), .req_i(req1), .we_i(1'b1), .size_i(2'b10),
      .sign_i(1'b0), .addr_i(32'd0), .wdata_i(32'd0), .ready_o(ready1),
      .ack_o(ack1), .rdata_o(rdata1), .err_o(err1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one access at a negedge, push its expected response, then wait for ack
   task automatic access(input string tag, input logic a_we, input logic [1:0] a_size,
                         input logic a_sign, input logic [31:0] a_addr,
                         input logic [31:0] a_wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
      int n;
      logic [32:0] e;
      n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, 32'(ready), 32'd1);
      req = 1'b1; we = a_we; size = a_size; sign = a_sign; addr = a_addr; wdata = a_wdata;
      @(posedge clk);
      exp_q.push_back({exp_err, exp_rdata});
      @(negedge clk);
      req = 1'b0;
      n = 0;
      while (!ack && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'(LAT));
      check({tag, "_ready_at_ack"}, 32'(ready), 32'd0);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_rdata"}, rdata, e[31:0]);
         check({tag, "_err"}, 32'(err), 32'(e[32]));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int last, nready, nack;
      rst_n = 1'b0; req = 1'b0; req1 = 1'b0; we = 1'b0; sign = 1'b0;
      size = 2'b00; addr = 32'd0; wdata = 32'd0;
      @(negedge clk); @(negedge clk);
      check("reset_ready", 32'(ready), 32'd1);
      check("reset_ack", 32'(ack), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      check("reset_rdata", rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset in the middle of a store must abort it
      access("pre_st10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11111111, 32'd0, 1'b0);
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      rst_n = 1'b0;
      #1;
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_ack", 32'(ack), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      access("abort_ld10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h11111111, 1'b0);

      // Latency and byte/half merging
      access("st8_word", 1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678, 32'd0, 1'b0);
      access("ld8_word", 1'b0, 2'b10, 1'b0, 32'h8, 32'd0, 32'h12345678, 1'b0);
      access("stb_b", 1'b1, 2'b00, 1'b0, 32'hB, 32'h000000AA, 32'd0, 1'b0);
      access("sth_8", 1'b1, 2'b01, 1'b0, 32'h8, 32'h0000BEEF, 32'd0, 1'b0);
      access("ld8_merge", 1'b0, 2'b10, 1'b0, 32'h8, 32'd0, 32'hAA34BEEF, 1'b0);

      // Sign and zero extension
      access("st0_word", 1'b1, 2'b10, 1'b0, 32'h0, 32'h80FF7F01, 32'd0, 1'b0);
      access("lb_2", 1'b0, 2'b00, 1'b1, 32'h2, 32'd0, 32'hFFFFFFFF, 1'b0);
      access("lbu_3", 1'b0, 2'b00, 1'b0, 32'h3, 32'd0, 32'h00000080, 1'b0);
      access("lh_2", 1'b0, 2'b01, 1'b1, 32'h2, 32'd0, 32'hFFFF80FF, 1'b0);
      access("lhu_0", 1'b0, 2'b01, 1'b0, 32'h0, 32'd0, 32'h00007F01, 1'b0);

      // Rejected accesses leave memory untouched
      access("st4_word", 1'b1, 2'b10, 1'b0, 32'h4, 32'h55667788, 32'd0, 1'b0);
      access("err_w6", 1'b1, 2'b10, 1'b0, 32'h6, 32'hFFFFFFFF, 32'd0, 1'b1);
      access("err_h5", 1'b1, 2'b01, 1'b0, 32'h5, 32'hFFFFFFFF, 32'd0, 1'b1);
      access("ld4_ok", 1'b0, 2'b10, 1'b0, 32'h4, 32'd0, 32'h55667788, 1'b0);
      access("err_sz3", 1'b0, 2'b11, 1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
      access("err_w400", 1'b1, 2'b10, 1'b0, 32'h400, 32'hFFFFFFFF, 32'd0, 1'b1);
      access("ld0_ok", 1'b0, 2'b10, 1'b0, 32'h0, 32'd0, 32'h80FF7F01, 1'b0);
      access("ld4_final", 1'b0, 2'b10, 1'b0, 32'h4, 32'd0, 32'h55667788, 1'b0);

      // Continuous request on the LATENCY=1 instance: one acceptance every 3 cycles
      @(negedge clk);
      req1 = 1'b1;
      last = -1; nready = 0; nack = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check("tp_no_overlap", 32'(ready1 && ack1), 32'd0);
         if (ready1) begin
            if (last >= 0) check("tp_gap", 32'(i - last), 32'd3);
            last = i;
            nready++;
         end
         if (ack1) begin
            nack++;
            check("tp_err", 32'(err1), 32'd0);
            check("tp_rdata", rdata1, 32'd0);
         end
      end
      req1 = 1'b0;
      check("tp_accepts", 32'(nready), 32'd5);
      check("tp_acks", 32'(nack), 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
